// File: rtl/adder_share_arbiter.sv
// Round-robin time-share of one external combinational 8-bit adder among NREQ requesters.
// Each transaction takes three cycles: grant (IDLE), adder settle (ISSUE) and response hold (HOLD).
module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        add_x1,
  output logic [7:0]        add_x2,
  input  logic [7:0]        add_s,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_sum,
  output logic [15:0]       done_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] rr_nxt;
  logic [IDW-1:0] idx_w;
  logic           found;
  int             idx;

  // Search upward from rr_ptr, wrapping modulo NREQ; first set bit wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(rr_ptr) + k) % NREQ;
      idx_w = IDW'(idx);
      if (!found && req_valid[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  assign rr_nxt    = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
  assign req_ready = (state == IDLE && found) ? (NREQ'(1) << winner) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = HOLD;
      HOLD:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant edge loads operands; ISSUE edge captures the adder; HOLD edge retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      add_x1    <= '0;
      add_x2    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      done_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            add_x1 <= req_a[8*winner +: 8];
            add_x2 <= req_b[8*winner +: 8];
            rsp_id <= winner;
            rr_ptr <= rr_nxt;
          end
        end
        ISSUE: begin
          rsp_sum   <= add_s;
          rsp_valid <= 1'b1;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: the bench plays the shared adder by driving add_s.
module tb_adder_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [7:0]  add_x1;
  logic [7:0]  add_x2;
  logic [7:0]  add_s;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic [15:0] done_cnt;

  int checks = 0;
  int errors = 0;

  adder_share_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_x1(add_x1), .add_x2(add_x2), .add_s(add_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; add_s = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (add_x1 !== 8'h00) begin errors++; $display("FAIL reset_add_x1: got %h expected 00", add_x1); end
    checks++; if (add_x2 !== 8'h00) begin errors++; $display("FAIL reset_add_x2: got %h expected 00", add_x2); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    checks++; if (rsp_sum !== 8'h00) begin errors++; $display("FAIL reset_rsp_sum: got %h expected 00", rsp_sum); end
    checks++; if (done_cnt !== 16'h0000) begin errors++; $display("FAIL reset_done_cnt: got %h expected 0000", done_cnt); end
    tick();
    #1;
    checks++; if ({rsp_valid, req_ready, done_cnt} !== 21'b0) begin errors++; $display("FAIL reset_idle: got %b/%b/%h expected 0/0000/0000", rsp_valid, req_ready, done_cnt); end
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_a[23:16] = 8'h05; req_b[23:16] = 8'h0A; rsp_ready = 1'b1; add_s = 8'hEE;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0; req_a = '0; req_b = '0; add_s = 8'h0F;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_grant_once: got %b expected 0000", req_ready); end
    checks++; if ({add_x1, add_x2} !== 16'h050A) begin errors++; $display("FAIL single_operands: got %h%h expected 050A", add_x1, add_x2); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_issue_valid: got %b expected 0", rsp_valid); end
    tick();
    add_s = 8'hEE;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id: got %0d expected 2", rsp_id); end
    checks++; if (rsp_sum !== 8'h0F) begin errors++; $display("FAIL single_rsp_sum: got %h expected 0F", rsp_sum); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL single_cnt_hold: got %0d expected 0", done_cnt); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_clear: got %b expected 0", rsp_valid); end
    checks++; if (done_cnt !== 16'd1) begin errors++; $display("FAIL single_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    rst = 1'b1; req_valid = '0;
    tick(); tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_a = 32'h40302010; req_b = 32'h04030201; rsp_ready = 1'b1; add_s = 8'hC3;
    for (int c = 0; c < 15; c++) begin
      #1;
      exp_rdy = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant_c%0d: got %b expected %b", c, req_ready, exp_rdy); end
      if (c % 3 == 2) begin
        exp_id = 2'((c / 3) % 4);
        checks++; if (rsp_id !== exp_id) begin errors++; $display("FAIL rr_rsp_id_c%0d: got %0d expected %0d", c, rsp_id, exp_id); end
      end
      tick();
    end
    req_valid = '0;
    #1;
    checks++; if (done_cnt !== 16'd5) begin errors++; $display("FAIL rr_done_cnt: got %0d expected 5", done_cnt); end
  endtask

  task automatic test_back_pressure();
    rsp_ready = 1'b0; req_valid = 4'b1010;
    req_a[15:8] = 8'h33; req_a[31:24] = 8'h99; req_b[15:8] = 8'h44; req_b[31:24] = 8'h88;
    add_s = 8'hEE;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b expected 0010", req_ready); end
    tick();
    req_a[15:8] = 8'hAB; req_b[15:8] = 8'hCD; add_s = 8'h77;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_issue_ready: got %b expected 0000", req_ready); end
    tick();
    add_s = 8'h11;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_sum, rsp_id, add_x1, add_x2, req_ready, done_cnt} !==
          {1'b1, 8'h77, 2'd1, 8'h33, 8'h44, 4'b0000, 16'd5}) begin
        errors++;
        $display("FAIL bp_hold_c%0d: got v=%b s=%h id=%0d x=%h%h rdy=%b cnt=%0d expected v=1 s=77 id=1 x=3344 rdy=0000 cnt=5",
                 c, rsp_valid, rsp_sum, rsp_id, add_x1, add_x2, req_ready, done_cnt);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", rsp_valid); end
    checks++; if (done_cnt !== 16'd6) begin errors++; $display("FAIL bp_release_cnt: got %0d expected 6", done_cnt); end
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_rearb: got %b expected 1000", req_ready); end
    req_valid = '0;
    #1;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100; req_a[23:16] = 8'h55; req_b[23:16] = 8'h66; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_grant: got %b expected 0100", req_ready); end
    tick();
    rst = 1'b1; req_valid = 4'b1010; add_s = 8'h5A;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL rmid_rr_ptr: got %0d expected 0", dut.rr_ptr); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_regrant: got %b expected 0010", req_ready); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL rmid_done_cnt: got %0d expected 0", done_cnt); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_issue_valid: got %b expected 0", rsp_valid); end
    tick();
    #1;
    checks++; if ({rsp_valid, rsp_id} !== 3'b101) begin errors++; $display("FAIL rmid_rsp: got v=%b id=%0d expected v=1 id=1", rsp_valid, rsp_id); end
    tick();
  endtask

  task automatic test_counter_wrap();
    req_valid = '0;
    force dut.done_cnt = 16'hFFFF;
    tick();
    release dut.done_cnt;
    #1;
    checks++; if (done_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected FFFF", done_cnt); end
    req_valid = 4'b0001; req_a[7:0] = 8'hFF; req_b[7:0] = 8'h02; rsp_ready = 1'b1;
    tick();
    req_valid = '0; add_s = 8'h01;
    tick();
    #1;
    checks++; if (rsp_sum !== 8'h01) begin errors++; $display("FAIL wrap_rsp_sum: got %h expected 01", rsp_sum); end
    tick();
    #1;
    checks++; if (done_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_done_cnt: got %h expected 0000", done_cnt); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap_rsp_valid: got %b expected 0", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_reset_mid();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin scheduler that time-shares one combinational 8-bit prefix adder between `NREQ` requesters. It accepts one operand pair per transaction over a valid/ready handshake and registers the operands onto the adder inputs. It then captures the adder output and returns it with the requester index over a second valid/ready handshake. It sits between the requesting datapaths and the single adder instance, which connects outside this block through the `add_*` ports.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: requester index width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  bit i: requester i presents operands.
- `req_a`  in  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- `req_b`  in  8*NREQ  operand B, same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot grant; bit i high means requester i's operands are taken this cycle.
- `add_x1`  out  8  registered operand A to the shared adder.
- `add_x2`  out  8  registered operand B to the shared adder.
- `add_s`  in  8  combinational adder result.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_sum`  out  8  captured `add_s`.
- `done_cnt`  out  16  count of completed responses; wraps.

## Operation
- FSM states are IDLE, ISSUE and HOLD. The reset state is IDLE.
- **IDLE**
  - If any `req_valid` bit is high, the winner is the first set bit found searching upward from `rr_ptr` and wrapping modulo NREQ.
  - `req_ready[winner]` is asserted combinationally this cycle. All other `req_ready` bits stay 0.
  - At the clock edge, the winner's `req_a`/`req_b` are loaded into `add_x1`/`add_x2`, the winner index is loaded into `rsp_id`, `rr_ptr` becomes (winner+1) mod NREQ, and the FSM moves to ISSUE.
  - If no `req_valid` bit is high, the FSM stays in IDLE and all registers hold.
- **ISSUE**
  - `add_x1`/`add_x2` stay stable on the adder inputs for the full cycle.
  - At the edge, `rsp_sum` is loaded from `add_s`, `rsp_valid` becomes 1, and the FSM moves to HOLD.
- **HOLD**
  - `rsp_valid`=1, and `rsp_sum`/`rsp_id`/`add_x*` are stable.
  - When `rsp_ready`=1 at the edge: `rsp_valid` becomes 0, `done_cnt` increments (0xFFFF wraps to 0x0000), and the FSM moves to IDLE.
  - When `rsp_ready`=0, the FSM stays in HOLD with all outputs stable.
- `req_ready` is 0 in ISSUE and HOLD regardless of `req_valid`.
- Requesters may change or drop `req_valid`, `req_a` and `req_b` in any cycle in which they are not granted. Inputs seen outside IDLE are ignored.
- No arithmetic is performed in this block. `rsp_sum` is exactly the adder's 8-bit output with no carry out.
- `rsp_ready` has no effect outside HOLD.

## Timing
- **Reset values:** FSM=IDLE, `rr_ptr`=0, `req_ready`=0, `add_x1`=`add_x2`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `done_cnt`=0.
- **Reset mid-transaction:** the operation in flight is dropped with no response, and `rr_ptr` returns to 0.
- **Latency:** a grant in cycle T gives ISSUE in T+1 and `rsp_valid`=1 from T+2.
- **Throughput:** one transaction per 3 cycles when `rsp_ready` is tied high.
- `req_ready` is combinational from `req_valid`, the state and `rr_ptr`. The only combinational dependency on `add_s` is the `rsp_sum` capture inside ISSUE.
- The adder path has one full cycle (ISSUE) from register to capture.
- A granted requester's operands are sampled only at the edge ending its grant cycle.

## Test plan
- **Reset state:** assert `rst` for 2 cycles, then idle. Require every output to equal its reset value.
- **Single request:** requester 2 presents a=0x05, b=0x0A with `rsp_ready`=1.
  - `req_ready`=0b0100 for exactly one cycle.
  - `add_x1`=0x05 and `add_x2`=0x0A in the next cycle.
  - `rsp_valid`=1 two cycles after the grant, with `rsp_id`=2, `rsp_sum` equal to the `add_s` value driven during ISSUE, and `done_cnt`=1 afterwards.
- **Round-robin:** hold all four `req_valid` high from reset. Require grant order 0, 1, 2, 3, 0, with each grant 3 cycles apart.
- **Back-pressure:** hold `rsp_ready`=0 for 10 cycles while `rsp_valid` is high.
  - `rsp_sum`, `rsp_id` and `add_x*` stay stable, `req_ready` stays 0 throughout, and `done_cnt` is unchanged.
  - Releasing `rsp_ready` completes the transaction and re-arbitrates one cycle later.
- **Reset mid-operation:** assert `rst` in ISSUE. `rsp_valid` stays 0, `rr_ptr` returns to 0, and the next grant goes to the lowest-indexed active requester.
- **Counter wrap:** preload `done_cnt` via 65535 transactions, or force it in simulation. The next completion must read 0x0000.
